// File: rtl/natv_tim.sv
// Timer/counter behind a native-memory-interface target port: prescaler, compare, overflow IRQ.
// Latency: one response pulse on nmi_ready_o exactly 1 clk after a request is accepted.
// Backpressure: no stalls; an accepted request blocks the next accept for one cycle (max 1 per 2 clk).
module natv_tim #(
  parameter int CNT_WIDTH  = 32,
  parameter int PSCR_WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        nmi_valid_i,
  input  logic [31:0] nmi_addr_i,
  input  logic [31:0] nmi_wdata_i,
  input  logic [3:0]  nmi_wstrb_i,
  output logic [31:0] nmi_rdata_o,
  output logic        nmi_ready_o,
  output logic        irq_o
);

  localparam logic [2:0] ADDR_CTRL = 3'd0;
  localparam logic [2:0] ADDR_PSCR = 3'd1;
  localparam logic [2:0] ADDR_CNT  = 3'd2;
  localparam logic [2:0] ADDR_CMP  = 3'd3;
  localparam logic [2:0] ADDR_STAT = 3'd4;

  // architectural state
  logic                  en;
  logic                  irqen;
  logic                  oneshot;
  logic [PSCR_WIDTH-1:0] pscr;
  logic [PSCR_WIDTH-1:0] pdiv;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  cmp;
  logic                  ovf;

  // access decode
  logic [2:0]  reg_idx;
  logic        acc;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_pscr;
  logic        wr_cnt;
  logic        wr_cmp;
  logic        wr_stat;
  logic        ovf_clr;

  // zero-extended register views and byte-merged write values
  logic [31:0] ctrl_ext;
  logic [31:0] pscr_ext;
  logic [31:0] cnt_ext;
  logic [31:0] cmp_ext;
  logic [31:0] pscr_new;
  logic [31:0] cnt_new;
  logic [31:0] cmp_new;
  logic [31:0] rd_mux;

  // counting
  logic        pdiv_hit;
  logic        tick;
  logic        cnt_match;
  logic        wrap;

  logic        unused_ok;

  // Replace only the strobed bytes of a register value.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  assign reg_idx = nmi_addr_i[4:2];
  assign acc     = nmi_valid_i & ~nmi_ready_o;
  assign wr      = acc & (|nmi_wstrb_i);
  assign wr_ctrl = wr & (reg_idx == ADDR_CTRL);
  assign wr_pscr = wr & (reg_idx == ADDR_PSCR);
  assign wr_cnt  = wr & (reg_idx == ADDR_CNT);
  assign wr_cmp  = wr & (reg_idx == ADDR_CMP);
  assign wr_stat = wr & (reg_idx == ADDR_STAT);
  assign ovf_clr = wr_stat & nmi_wstrb_i[0] & nmi_wdata_i[0];

  // Prescaler terminal count produces a tick; a SW write of CNT on the same edge swallows
  // the tick entirely, so it can neither overflow nor stop a one-shot.
  assign pdiv_hit  = (pdiv == pscr);
  assign tick      = en & pdiv_hit;
  assign cnt_match = (cnt == cmp);
  assign wrap      = tick & cnt_match & ~wr_cnt;

  // Widen registers to bus width and build merged write data.
  always_comb begin
    ctrl_ext = '0;
    pscr_ext = '0;
    cnt_ext  = '0;
    cmp_ext  = '0;
    ctrl_ext[2:0]            = {oneshot, irqen, en};
    pscr_ext[PSCR_WIDTH-1:0] = pscr;
    cnt_ext[CNT_WIDTH-1:0]   = cnt;
    cmp_ext[CNT_WIDTH-1:0]   = cmp;
    pscr_new = byte_merge(pscr_ext, nmi_wdata_i, nmi_wstrb_i);
    cnt_new  = byte_merge(cnt_ext,  nmi_wdata_i, nmi_wstrb_i);
    cmp_new  = byte_merge(cmp_ext,  nmi_wdata_i, nmi_wstrb_i);
  end

  // Read data mux; unmapped slots read as zero.
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      ADDR_CTRL: rd_mux = ctrl_ext;
      ADDR_PSCR: rd_mux = pscr_ext;
      ADDR_CNT:  rd_mux = cnt_ext;
      ADDR_CMP:  rd_mux = cmp_ext;
      ADDR_STAT: rd_mux = {31'd0, ovf};
      default:   rd_mux = '0;
    endcase
  end

  // Bits intentionally ignored: undecoded address bits and bytes above the register widths.
  assign unused_ok = ^{nmi_addr_i[31:5], nmi_addr_i[1:0], pscr_new, cnt_new, cmp_new};

  // Response: single-cycle ready pulse with read data captured on the accept edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      nmi_ready_o <= 1'b0;
      nmi_rdata_o <= '0;
    end else begin
      nmi_ready_o <= acc;
      if (acc) nmi_rdata_o <= rd_mux;
    end
  end

  // CTRL: a SW write of the low byte overrides the one-shot auto-disable.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en      <= 1'b0;
      irqen   <= 1'b0;
      oneshot <= 1'b0;
    end else if (wr_ctrl && nmi_wstrb_i[0]) begin
      en      <= nmi_wdata_i[0];
      irqen   <= nmi_wdata_i[1];
      oneshot <= nmi_wdata_i[2];
    end else if (wrap && oneshot) begin
      en      <= 1'b0;
    end
  end

  // PSCR and CMP: plain byte-strobed registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pscr <= '0;
      cmp  <= '0;
    end else begin
      if (wr_pscr) pscr <= pscr_new[PSCR_WIDTH-1:0];
      if (wr_cmp)  cmp  <= cmp_new[CNT_WIDTH-1:0];
    end
  end

  // Prescale divider: restarts on any PSCR write, holds while disabled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pdiv <= '0;
    end else if (wr_pscr) begin
      pdiv <= '0;
    end else if (en) begin
      pdiv <= pdiv_hit ? '0 : pdiv + PSCR_WIDTH'(1);
    end
  end

  // Main counter: SW write beats the tick; on a compare hit it restarts from zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
    end else if (wr_cnt) begin
      cnt <= cnt_new[CNT_WIDTH-1:0];
    end else if (tick) begin
      cnt <= cnt_match ? '0 : cnt + CNT_WIDTH'(1);
    end
  end

  // Overflow flag: hardware set dominates a simultaneous write-one-to-clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf <= 1'b0;
    end else begin
      ovf <= wrap | (ovf & ~ovf_clr);
    end
  end

  assign irq_o = ovf & irqen;

endmodule
